per_master_arbiter: RTL and testbench

- Shares one peripheral-interconnect master port (req/add/wen/wdata/be/gnt plus r_valid/r_opc/r_rdata) among NB_REQ requesters, e.g. the AXI-to-peripheral bridge, a debug path and a DMA configuration path.
- Round-robin arbitration picks the requester. A selection that has been presented downstream but not yet granted is held.
- An in-order FIFO tracks outstanding transactions so that each response goes back to the requester that issued it.
- Sits between the requesters and the cluster peripheral interconnect.

---
 rtl/per_master_arbiter_pkg.sv | 18 +
 rtl/fifo_v3.sv | 62 ++++++
 rtl/per_master_arbiter.sv | 124 ++++++++++++
 tb/tb_per_master_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/per_master_arbiter_pkg.sv
// Cluster-wide constants for the peripheral master arbiter: requester slot indices and a modulo helper.
package per_master_arbiter_pkg;

  localparam int unsigned NB_REQ_DEFAULT = 3;

  typedef enum logic [1:0] {
    REQ_AXI_BRIDGE = 2'd0,
    REQ_DEBUG      = 2'd1,
    REQ_DMA_CFG    = 2'd2
  } req_slot_e;

  function automatic int unsigned wrap_add(input int unsigned base,
                                           input int unsigned ofs,
                                           input int unsigned n);
    return (base + ofs) % n;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO, optional fall-through; one-cycle write-to-read latency otherwise.
// Pushes while full and pops while empty are ignored; flush_i clears the contents.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [PTR_W:0]        cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  stored_empty, do_push, do_pop, bypass, upd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign stored_empty = (cnt == '0);
  assign full_o       = (cnt == (PTR_W+1)'(DEPTH));
  assign empty_o      = stored_empty & ~(FALL_THROUGH & push_i);
  assign data_o       = (FALL_THROUGH && stored_empty) ? data_i : mem[rd_ptr];
  assign do_push      = push_i & ~full_o;
  assign do_pop       = pop_i & ~empty_o;
  assign bypass       = FALL_THROUGH & stored_empty & do_push & do_pop;
  // Clock-gate style enable; test mode keeps the state registers always enabled.
  assign upd_en       = push_i | pop_i | flush_i | testmode_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (upd_en) begin
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else if (!bypass) begin
        if (do_push) wr_ptr <= ptr_inc(wr_ptr);
        if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
        cnt <= cnt + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !bypass && !flush_i) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/per_master_arbiter.sv
// Round-robin share of one peripheral master port; grant and response routing are combinational.
// An ungranted selection is held stable; requests stop while MAX_OUTSTANDING responses are pending.
module per_master_arbiter
  import per_master_arbiter_pkg::*;
#(
  parameter int unsigned NB_REQ          = NB_REQ_DEFAULT,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         test_en_i,
  input  logic [NB_REQ-1:0]            slv_req_i,
  input  logic [NB_REQ*ADDR_WIDTH-1:0] slv_add_i,
  input  logic [NB_REQ-1:0]            slv_wen_i,
  input  logic [NB_REQ*DATA_WIDTH-1:0] slv_wdata_i,
  input  logic [NB_REQ*BE_WIDTH-1:0]   slv_be_i,
  output logic [NB_REQ-1:0]            slv_gnt_o,
  output logic [NB_REQ-1:0]            slv_r_valid_o,
  output logic [DATA_WIDTH-1:0]        slv_r_rdata_o,
  output logic                         slv_r_opc_o,
  output logic                         mst_req_o,
  output logic [ADDR_WIDTH-1:0]        mst_add_o,
  output logic                         mst_wen_o,
  output logic [DATA_WIDTH-1:0]        mst_wdata_o,
  output logic [BE_WIDTH-1:0]          mst_be_o,
  input  logic                         mst_gnt_i,
  input  logic                         mst_r_valid_i,
  input  logic                         mst_r_opc_i,
  input  logic [DATA_WIDTH-1:0]        mst_r_rdata_i,
  output logic                         busy_o,
  output logic                         err_o
);
  localparam int unsigned IDX_WIDTH = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  typedef logic [IDX_WIDTH-1:0] idx_t;

  idx_t rr_ptr, lock_idx, arb_idx, sel, fifo_head;
  logic lock, arb_vld, lock_hold, sel_vld;
  logic fifo_full, fifo_empty, hs, pop;

  always_comb begin
    idx_t cand;
    cand    = '0;
    arb_vld = 1'b0;
    arb_idx = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      cand = idx_t'(wrap_add(32'(rr_ptr), i, NB_REQ));
      if (!arb_vld && slv_req_i[cand]) begin
        arb_vld = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // A locked requester that drops its request falls back to fresh arbitration.
  assign lock_hold = lock & slv_req_i[lock_idx];
  assign sel_vld   = lock_hold | arb_vld;
  assign sel       = lock_hold ? lock_idx : arb_idx;
  assign mst_req_o = sel_vld & ~fifo_full;
  assign hs        = mst_req_o & mst_gnt_i;

  always_comb begin
    mst_add_o     = '0;
    mst_wen_o     = 1'b0;
    mst_wdata_o   = '0;
    mst_be_o      = '0;
    slv_gnt_o     = '0;
    slv_r_valid_o = '0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      if (sel_vld && sel == idx_t'(k)) begin
        mst_add_o    = slv_add_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        mst_wen_o    = slv_wen_i[k];
        mst_wdata_o  = slv_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        mst_be_o     = slv_be_i[k*BE_WIDTH +: BE_WIDTH];
        slv_gnt_o[k] = hs;
      end
      slv_r_valid_o[k] = pop && (fifo_head == idx_t'(k));
    end
  end

  assign pop           = mst_r_valid_i & ~fifo_empty;
  assign err_o         = mst_r_valid_i & fifo_empty;
  assign slv_r_rdata_o = mst_r_rdata_i;
  assign slv_r_opc_o   = mst_r_opc_i;
  assign busy_o        = mst_req_o | ~fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (mst_req_o) begin
      if (mst_gnt_i) begin
        rr_ptr <= idx_t'(wrap_add(32'(sel), 1, NB_REQ));
        lock   <= 1'b0;
      end else begin
        lock     <= 1'b1;
        lock_idx <= sel;
      end
    end else if (lock && !slv_req_i[lock_idx]) begin
      lock <= 1'b0;
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (IDX_WIDTH),
    .DEPTH        (MAX_OUTSTANDING)
  ) i_outstanding_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (test_en_i),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .data_i     (sel),
    .push_i     (hs),
    .data_o     (fifo_head),
    .pop_i      (pop)
  );

endmodule

// File: tb/tb_per_master_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and random traffic against a queue model.
module tb_per_master_arbiter;
  import per_master_arbiter_pkg::*;

  localparam int NB = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MO = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni, test_en_i;
  logic [NB-1:0]     slv_req_i, slv_wen_i, slv_gnt_o, slv_r_valid_o;
  logic [NB*AW-1:0]  slv_add_i;
  logic [NB*DW-1:0]  slv_wdata_i;
  logic [NB*BW-1:0]  slv_be_i;
  logic [DW-1:0]     slv_r_rdata_o, mst_wdata_o, mst_r_rdata_i;
  logic              slv_r_opc_o, mst_req_o, mst_wen_o, mst_gnt_i;
  logic              mst_r_valid_i, mst_r_opc_i, busy_o, err_o;
  logic [AW-1:0]     mst_add_o;
  logic [BW-1:0]     mst_be_o;

  always #5 clk_i = ~clk_i;

  per_master_arbiter #(
    .NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_en_i(test_en_i),
    .slv_req_i(slv_req_i), .slv_add_i(slv_add_i), .slv_wen_i(slv_wen_i),
    .slv_wdata_i(slv_wdata_i), .slv_be_i(slv_be_i), .slv_gnt_o(slv_gnt_o),
    .slv_r_valid_o(slv_r_valid_o), .slv_r_rdata_o(slv_r_rdata_o), .slv_r_opc_o(slv_r_opc_o),
    .mst_req_o(mst_req_o), .mst_add_o(mst_add_o), .mst_wen_o(mst_wen_o),
    .mst_wdata_o(mst_wdata_o), .mst_be_o(mst_be_o), .mst_gnt_i(mst_gnt_i),
    .mst_r_valid_i(mst_r_valid_i), .mst_r_opc_i(mst_r_opc_i), .mst_r_rdata_i(mst_r_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  int n_tests = 0;
  int n_fails = 0;

  // Reference model: round-robin pointer, lock, and a queue of outstanding requester ids.
  int m_rr, m_lidx, m_sel;
  bit m_lock, m_mreq, m_hs, m_pop;
  int m_q[$];

  typedef struct {
    logic [2:0] req;
    logic       gnt;
    logic       rv;
    logic [2:0] e_gnt;
    logic [2:0] e_rvo;
    logic       e_mreq;
    logic       e_err;
    logic       e_busy;
    int         e_sel;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] def_addr(input int k);
    return 32'h1020_0004 + 32'(k) * 32'h0000_1000;
  endfunction

  task automatic set_default_payload();
    for (int k = 0; k < NB; k++) begin
      slv_add_i[k*AW +: AW]   = def_addr(k);
      slv_wdata_i[k*DW +: DW] = 32'hDEAD_BEEF ^ (32'(k) << 8);
    end
    slv_wen_i = 3'b110;
    slv_be_i  = {4'hC, 4'h3, 4'hF};
  endtask

  task automatic drive(input logic [2:0] req, input logic gnt, input logic rv);
    slv_req_i     = req;
    mst_gnt_i     = gnt;
    mst_r_valid_i = rv;
    mst_r_rdata_i = $urandom();
    mst_r_opc_i   = 1'($urandom_range(0, 1));
  endtask

  task automatic eval_cycle();
    int  sel, k;
    bit  found;
    logic [63:0] e_gnt, e_rvo;
    @(negedge clk_i);
    found = 1'b0;
    sel   = 0;
    if (m_lock && slv_req_i[m_lidx]) begin
      found = 1'b1;
      sel   = m_lidx;
    end else begin
      for (int i = 0; i < NB; i++) begin
        k = (m_rr + i) % NB;
        if (!found && slv_req_i[k]) begin
          found = 1'b1;
          sel   = k;
        end
      end
    end
    m_sel  = sel;
    m_mreq = found && (m_q.size() < MO);
    m_hs   = m_mreq && mst_gnt_i;
    m_pop  = mst_r_valid_i && (m_q.size() > 0);
    e_gnt  = m_hs ? (64'd1 << sel) : 64'd0;
    e_rvo  = m_pop ? (64'd1 << m_q[0]) : 64'd0;
    chk("model mst_req", 64'(mst_req_o), 64'(m_mreq));
    chk("model mst_add", 64'(mst_add_o), found ? 64'(slv_add_i[sel*AW +: AW]) : 64'd0);
    chk("model mst_wen", 64'(mst_wen_o), found ? 64'(slv_wen_i[sel]) : 64'd0);
    chk("model mst_wdata", 64'(mst_wdata_o), found ? 64'(slv_wdata_i[sel*DW +: DW]) : 64'd0);
    chk("model mst_be", 64'(mst_be_o), found ? 64'(slv_be_i[sel*BW +: BW]) : 64'd0);
    chk("model slv_gnt", 64'(slv_gnt_o), e_gnt);
    chk("model slv_r_valid", 64'(slv_r_valid_o), e_rvo);
    chk("model r_rdata", 64'(slv_r_rdata_o), 64'(mst_r_rdata_i));
    chk("model r_opc", 64'(slv_r_opc_o), 64'(mst_r_opc_i));
    chk("model err", 64'(err_o), 64'(mst_r_valid_i && m_q.size() == 0));
    chk("model busy", 64'(busy_o), 64'(m_mreq || m_q.size() > 0));
  endtask

  task automatic commit();
    @(posedge clk_i);
    if (m_pop) void'(m_q.pop_front());
    if (m_hs) begin
      m_q.push_back(m_sel);
      m_rr   = (m_sel + 1) % NB;
      m_lock = 1'b0;
    end else if (m_mreq) begin
      m_lock = 1'b1;
      m_lidx = m_sel;
    end else if (m_lock && !slv_req_i[m_lidx]) begin
      m_lock = 1'b0;
    end
    #1;
  endtask

  task automatic cycle();
    eval_cycle();
    commit();
  endtask

  task automatic do_reset(input string tag);
    slv_req_i     = '0;
    mst_gnt_i     = 1'b0;
    mst_r_valid_i = 1'b0;
    mst_r_rdata_i = '0;
    mst_r_opc_i   = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk({tag, " mst_req"}, 64'(mst_req_o), 64'd0);
    chk({tag, " mst_add"}, 64'(mst_add_o), 64'd0);
    chk({tag, " slv_gnt"}, 64'(slv_gnt_o), 64'd0);
    chk({tag, " slv_r_valid"}, 64'(slv_r_valid_o), 64'd0);
    chk({tag, " busy"}, 64'(busy_o), 64'd0);
    chk({tag, " err"}, 64'(err_o), 64'd0);
    m_q.delete();
    m_rr   = 0;
    m_lock = 1'b0;
    m_lidx = 0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got t=%0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni    = 1'b0;
    test_en_i = 1'b0;
    set_default_payload();
    do_reset("reset");

    //            req     g     rv    e_gnt   e_rvo  mreq  err   busy  sel
    tbl.push_back(vec_t'{3'b111, 1'b1, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 1'b1, 0});
    tbl.push_back(vec_t'{3'b111, 1'b1, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 1'b1, 1});
    tbl.push_back(vec_t'{3'b111, 1'b1, 1'b1, 3'b100, 3'b001, 1'b1, 1'b0, 1'b1, 2});
    tbl.push_back(vec_t'{3'b111, 1'b1, 1'b1, 3'b001, 3'b010, 1'b1, 1'b0, 1'b1, 0});
    tbl.push_back(vec_t'{3'b000, 1'b0, 1'b1, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, -1});
    tbl.push_back(vec_t'{3'b000, 1'b0, 1'b1, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, -1});
    tbl.push_back(vec_t'{3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, -1});
    tbl.push_back(vec_t'{3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, -1});
    tbl.push_back(vec_t'{3'b100, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 2});
    tbl.push_back(vec_t'{3'b110, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 2});
    tbl.push_back(vec_t'{3'b110, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 2});
    tbl.push_back(vec_t'{3'b110, 1'b1, 1'b0, 3'b100, 3'b000, 1'b1, 1'b0, 1'b1, 2});
    tbl.push_back(vec_t'{3'b010, 1'b1, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 1'b1, 1});
    tbl.push_back(vec_t'{3'b000, 1'b0, 1'b1, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, -1});
    tbl.push_back(vec_t'{3'b000, 1'b0, 1'b1, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, -1});
    tbl.push_back(vec_t'{3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, -1});
    tbl.push_back(vec_t'{3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 0});
    tbl.push_back(vec_t'{3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1});
    tbl.push_back(vec_t'{3'b010, 1'b1, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 1'b1, 1});
    tbl.push_back(vec_t'{3'b000, 1'b0, 1'b1, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, -1});

    foreach (tbl[r]) begin
      drive(tbl[r].req, tbl[r].gnt, tbl[r].rv);
      eval_cycle();
      chk($sformatf("tbl%0d gnt", r), 64'(slv_gnt_o), 64'(tbl[r].e_gnt));
      chk($sformatf("tbl%0d r_valid", r), 64'(slv_r_valid_o), 64'(tbl[r].e_rvo));
      chk($sformatf("tbl%0d mst_req", r), 64'(mst_req_o), 64'(tbl[r].e_mreq));
      chk($sformatf("tbl%0d err", r), 64'(err_o), 64'(tbl[r].e_err));
      chk($sformatf("tbl%0d busy", r), 64'(busy_o), 64'(tbl[r].e_busy));
      chk($sformatf("tbl%0d mst_add", r), 64'(mst_add_o),
          (tbl[r].e_sel < 0) ? 64'd0 : 64'(def_addr(tbl[r].e_sel)));
      commit();
    end

    // Single write from the AXI bridge, response two cycles after the grant.
    drive(3'b001 << REQ_AXI_BRIDGE, 1'b1, 1'b0);
    eval_cycle();
    chk("single mst_add", 64'(mst_add_o), 64'h1020_0004);
    chk("single mst_wdata", 64'(mst_wdata_o), 64'hDEAD_BEEF);
    chk("single mst_wen", 64'(mst_wen_o), 64'd0);
    chk("single gnt", 64'(slv_gnt_o), 64'b001);
    commit();
    drive(3'b000, 1'b0, 1'b0);
    cycle();
    drive(3'b000, 1'b0, 1'b1);
    eval_cycle();
    chk("single r_valid", 64'(slv_r_valid_o), 64'b001);
    commit();

    // Back-pressure: four grants fill the tracker (rr starts at 1: 1,2,0,1).
    for (int i = 0; i < MO; i++) begin
      drive(3'b111, 1'b1, 1'b0);
      cycle();
    end
    drive(3'b111, 1'b1, 1'b0);
    eval_cycle();
    chk("bp full mst_req", 64'(mst_req_o), 64'd0);
    chk("bp full gnt", 64'(slv_gnt_o), 64'd0);
    commit();
    drive(3'b111, 1'b1, 1'b1);
    eval_cycle();
    chk("bp pop mst_req", 64'(mst_req_o), 64'd0);
    chk("bp pop r_valid", 64'(slv_r_valid_o), 64'b010);
    commit();
    drive(3'b111, 1'b1, 1'b0);
    eval_cycle();
    chk("bp reassert mst_req", 64'(mst_req_o), 64'd1);
    chk("bp reassert gnt", 64'(slv_gnt_o), 64'b100);
    commit();
    for (int i = 0; i < MO; i++) begin
      drive(3'b000, 1'b0, 1'b1);
      cycle();
    end

    // Simultaneous push and pop.
    drive(3'b010, 1'b1, 1'b0);
    cycle();
    drive(3'b100, 1'b1, 1'b1);
    eval_cycle();
    chk("pushpop r_valid", 64'(slv_r_valid_o), 64'b010);
    chk("pushpop gnt", 64'(slv_gnt_o), 64'b100);
    commit();
    drive(3'b000, 1'b0, 1'b1);
    eval_cycle();
    chk("pushpop next r_valid", 64'(slv_r_valid_o), 64'b100);
    chk("pushpop busy", 64'(busy_o), 64'd1);
    commit();

    // Reset mid-burst, then a late response must be flagged.
    drive(3'b111, 1'b1, 1'b0);
    cycle();
    cycle();
    do_reset("midrst");
    drive(3'b000, 1'b0, 1'b1);
    eval_cycle();
    chk("late rsp err", 64'(err_o), 64'd1);
    chk("late rsp r_valid", 64'(slv_r_valid_o), 64'd0);
    commit();
    drive(3'b000, 1'b0, 1'b0);
    eval_cycle();
    chk("late rsp err clears", 64'(err_o), 64'd0);
    commit();

    // Random traffic, including requests dropped while locked and spurious responses.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) test_en_i = 1'b1;
      slv_req_i     = 3'($urandom_range(0, 7));
      slv_add_i     = {$urandom(), $urandom(), $urandom()};
      slv_wdata_i   = {$urandom(), $urandom(), $urandom()};
      slv_be_i      = 12'($urandom());
      slv_wen_i     = 3'($urandom());
      mst_gnt_i     = ($urandom_range(0, 3) != 0);
      mst_r_valid_i = (m_q.size() > 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
      mst_r_rdata_i = $urandom();
      mst_r_opc_i   = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
